// File: rtl/traffic_light_controller.sv
// Main/side street traffic-light controller with pedestrian walk phase.
// Ticked interval timer, sensor extension and run-time interval reprogramming.
module traffic_light_controller #(
  parameter int TICK_DIV   = 10,
  parameter int T_BASE_DEF = 6,
  parameter int T_EXT_DEF  = 3,
  parameter int T_YEL_DEF  = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sensor,
  input  logic       Walk_Request,
  input  logic       Reprogram,
  input  logic [1:0] Time_Parameter_Selector,
  input  logic [3:0] Time_Value,
  output logic [6:0] LEDs
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] MAIN_G1 = 3'd0;
  localparam logic [2:0] MAIN_G2 = 3'd1;
  localparam logic [2:0] MAIN_Y  = 3'd2;
  localparam logic [2:0] WALK    = 3'd3;
  localparam logic [2:0] SIDE_G  = 3'd4;
  localparam logic [2:0] SIDE_GX = 3'd5;
  localparam logic [2:0] SIDE_Y  = 3'd6;

  logic [1:0]    sen_q, wreq_q;
  logic [2:0]    rp_q;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    tbase_q, tbase_d;
  logic [3:0]    text_q, text_d;
  logic [3:0]    tyel_q, tyel_d;
  logic          wl_q, wl_d;
  logic [6:0]    leds_q, leds_d;

  logic          sen_s, wreq_s, rp_edge;
  logic          tick, expired, load;
  logic [3:0]    ival, nv;

  assign sen_s   = sen_q[1];
  assign wreq_s  = wreq_q[1];
  assign rp_edge = rp_q[1] & ~rp_q[2];
  assign tick    = (div_q == DW'(TICK_DIV - 1));
  assign expired = tick && (cnt_q == 4'd1);
  assign nv      = (Time_Value == 4'd0) ? 4'd1 : Time_Value;
  assign LEDs    = leds_q;

  function automatic logic [6:0] dec(input logic [2:0] s);
    logic [6:0] l;
    l = 7'b0011000;
    case (s)
      MAIN_Y:          l = 7'b0101000;
      WALK:            l = 7'b1001001;
      SIDE_G, SIDE_GX: l = 7'b1000010;
      SIDE_Y:          l = 7'b1000100;
      default:         l = 7'b0011000;
    endcase
    return l;
  endfunction

  always_comb begin
    tbase_d = tbase_q;
    text_d  = text_q;
    tyel_d  = tyel_q;
    state_d = state_q;
    load    = 1'b0;
    ival    = tbase_q;
    // reprogram beats a simultaneous expiry
    if (rp_edge) begin
      case (Time_Parameter_Selector)
        2'b00:   tbase_d = nv;
        2'b01:   text_d  = nv;
        2'b10:   tyel_d  = nv;
        default: ;
      endcase
      state_d = MAIN_G1;
      load    = 1'b1;
      ival    = tbase_d;
    end else if (expired) begin
      load = 1'b1;
      case (state_q)
        MAIN_G1: begin
          state_d = MAIN_G2;
          ival    = sen_s ? text_q : tbase_q;
        end
        MAIN_G2: begin
          state_d = MAIN_Y;
          ival    = tyel_q;
        end
        MAIN_Y: begin
          state_d = wl_q ? WALK : SIDE_G;
          ival    = wl_q ? text_q : tbase_q;
        end
        WALK: begin
          state_d = SIDE_G;
          ival    = tbase_q;
        end
        SIDE_G: begin
          state_d = sen_s ? SIDE_GX : SIDE_Y;
          ival    = sen_s ? text_q : tyel_q;
        end
        SIDE_GX: begin
          state_d = SIDE_Y;
          ival    = tyel_q;
        end
        default: begin
          state_d = MAIN_G1;
          ival    = tbase_q;
        end
      endcase
    end
  end

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = '0;
      cnt_d = ival;
    end else if (tick) begin
      div_d = '0;
      cnt_d = cnt_q - 4'd1;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_comb begin
    wl_d = wl_q;
    if (load && state_d == WALK) wl_d = 1'b0;
    else if (wreq_s)             wl_d = 1'b1;
  end

  assign leds_d = dec(state_d);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sen_q   <= '0;
      wreq_q  <= '0;
      rp_q    <= '0;
      state_q <= MAIN_G1;
      div_q   <= '0;
      cnt_q   <= 4'(T_BASE_DEF);
      tbase_q <= 4'(T_BASE_DEF);
      text_q  <= 4'(T_EXT_DEF);
      tyel_q  <= 4'(T_YEL_DEF);
      wl_q    <= 1'b0;
      leds_q  <= 7'b0011000;
    end else begin
      sen_q   <= {sen_q[0], Sensor};
      wreq_q  <= {wreq_q[0], Walk_Request};
      rp_q    <= {rp_q[1:0], Reprogram};
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tbase_q <= tbase_d;
      text_q  <= text_d;
      tyel_q  <= tyel_d;
      wl_q    <= wl_d;
      leds_q  <= leds_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: expected light phases (pattern, length in clks) are queued
// from an interval model; a negedge monitor measures actual phases and compares.
module tb_traffic_light_controller;

  logic       clk;
  logic       Reset;
  logic       Sensor;
  logic       Walk_Request;
  logic       Reprogram;
  logic [1:0] Time_Parameter_Selector;
  logic [3:0] Time_Value;
  logic [6:0] LEDs;

  localparam logic [6:0] L_MG = 7'b0011000;
  localparam logic [6:0] L_MY = 7'b0101000;
  localparam logic [6:0] L_WK = 7'b1001001;
  localparam logic [6:0] L_SG = 7'b1000010;
  localparam logic [6:0] L_SY = 7'b1000100;

  typedef struct {
    logic [6:0] led;
    int         len;
  } ph_t;

  ph_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int tB, tE, tY;
  bit hold, skip_next, s_cur;
  logic [6:0] cur;
  int len;

  traffic_light_controller dut (
    .clk                     (clk),
    .Reset                   (Reset),
    .Sensor                  (Sensor),
    .Walk_Request            (Walk_Request),
    .Reprogram               (Reprogram),
    .Time_Parameter_Selector (Time_Parameter_Selector),
    .Time_Value              (Time_Value),
    .LEDs                    (LEDs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full light cycle as the street sees it: merged green phases.
  task automatic push_cycle(input bit s, input bit w);
    ph_t p;
    p.led = L_MG; p.len = 10 * (tB + (s ? tE : tB)); exp_q.push_back(p);
    p.led = L_MY; p.len = 10 * tY;                   exp_q.push_back(p);
    if (w) begin
      p.led = L_WK; p.len = 10 * tE; exp_q.push_back(p);
    end
    p.led = L_SG; p.len = 10 * (tB + (s ? tE : 0));  exp_q.push_back(p);
    p.led = L_SY; p.len = 10 * tY;                   exp_q.push_back(p);
  endtask

  task automatic wait_led(input logic [6:0] want, input bit drain);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!((!drain || exp_q.size() <= 1) && LEDs == want) && n < 3000);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL wait_led: LEDs=%b required=%b timed out", LEDs, want);
    end
  endtask

  task automatic scenario(input logic [1:0] sel, input logic [3:0] val,
                          input bit s, input bit w);
    int nv;
    wait_led(L_SY, 1'b1);
    exp_q.delete();
    skip_next = 1'b1;
    nv = (val == 0) ? 1 : int'(val);
    case (sel)
      2'd0:    tB = nv;
      2'd1:    tE = nv;
      2'd2:    tY = nv;
      default: ;
    endcase
    push_cycle(s, w);
    s_cur = s;
    Sensor = s;
    Time_Parameter_Selector = sel;
    Time_Value = val;
    Reprogram = 1'b1;
    repeat (4) @(posedge clk);
    #2 Reprogram = 1'b0;
    if (w) begin
      Walk_Request = 1'b1;
      repeat (2) @(posedge clk);
      #2 Walk_Request = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (hold) begin
      cur = LEDs;
      len = 0;
    end else if (LEDs === cur) begin
      len++;
    end else begin
      if (skip_next) begin
        skip_next = 1'b0;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL phase: unexpected %b len=%0d required=none", cur, len);
      end else begin
        ph_t e;
        e = exp_q.pop_front();
        checks++;
        if (e.led !== cur || e.len != len) begin
          errors++;
          $display("FAIL phase: got %b len=%0d required %b len=%0d",
                   cur, len, e.led, e.len);
        end
      end
      cur = LEDs;
      len = 1;
    end
  end

  initial begin
    hold = 1'b1;
    skip_next = 1'b0;
    Reset = 1'b1;
    Sensor = 1'b0;
    Walk_Request = 1'b0;
    Reprogram = 1'b0;
    Time_Parameter_Selector = 2'b11;
    Time_Value = 4'd0;
    tB = 6; tE = 3; tY = 2;
    s_cur = 1'b0;
    push_cycle(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (LEDs !== L_MG) begin
      errors++;
      $display("FAIL reset_leds: got %b required %b", LEDs, L_MG);
    end
    Reset = 1'b0;
    hold = 1'b0;

    scenario(2'b11, 4'd0, 1'b1, 1'b1);
    scenario(2'b00, 4'd4, 1'b0, 1'b0);
    scenario(2'b10, 4'd0, 1'b0, 1'b0);
    scenario(2'b11, 4'd9, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      scenario(2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // run into side green, then hit async reset there
    wait_led(L_SY, 1'b1);
    push_cycle(s_cur, 1'b0);
    wait_led(L_SG, 1'b0);
    Reset = 1'b1;
    #1;
    checks++;
    if (LEDs !== L_MG) begin
      errors++;
      $display("FAIL async_reset: got %b required %b", LEDs, L_MG);
    end
    hold = 1'b1;
    skip_next = 1'b0;
    exp_q.delete();
    Sensor = 1'b0;
    s_cur = 1'b0;
    tB = 6; tE = 3; tY = 2;
    push_cycle(1'b0, 1'b0);
    @(posedge clk);
    #1;
    Reset = 1'b0;
    hold = 1'b0;
    wait_led(L_SY, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
